// File: rtl/a2600_bs_detect.sv
// a2600_bs_detect: infers the Atari 2600 bank-switch scheme, SuperChip RAM and image size
// from the cartridge bytes as they stream over the ioctl download bus.
module a2600_bs_detect #(
    parameter int HIT_W  = 4,
    parameter int SC_LEN = 256
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [16:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [3:0]  ext_bs,
    input  logic        sc_cfg,
    output logic [3:0]  force_bs,
    output logic        sc,
    output logic [16:0] rom_size,
    output logic        valid
);
    typedef enum logic [1:0] {IDLE, SCAN, DECIDE, DONE} state_t;
    localparam int H_F8 = 0, H_F6 = 1, H_F4 = 2, H_E0 = 3, H_FA = 4, H_3F = 5, H_FE = 6;

    state_t            state_q, state_d;
    logic              dl_q, dl_prev_q;
    logic [7:0]        w0_q, w1_q, w2_q, w0_d, w1_d, w2_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [16:0]       prev_q, prev_d;
    logic [17:0]       size_q, size_d;
    logic [HIT_W-1:0]  hit_q [7];
    logic [HIT_W-1:0]  hit_d [7];
    logic [31:0]       sc_flag_q, sc_flag_d, sc_wr_q, sc_wr_d;
    logic [7:0]        sc_ref_q [32];
    logic [7:0]        sc_ref_d [32];
    logic [3:0]        force_bs_q, force_bs_d;
    logic              sc_q, sc_d, valid_q, valid_d;
    logic [16:0]       rom_size_q, rom_size_d;

    logic              rise, fall, wr_en, seq, abs_hit, sc_det;
    logic [7:0]        n0, n1, n2;
    logic [1:0]        ncnt;
    logic [6:0]        match;
    logic [17:0]       a1;
    logic [4:0]        bank;
    logic [11:0]       off;
    logic [3:0]        bs, bs_8k;

    assign force_bs = force_bs_q;
    assign sc       = sc_q;
    assign rom_size = rom_size_q;
    assign valid    = valid_q;

    always_comb begin
        rise    = dl_q & ~dl_prev_q;
        fall    = ~dl_q & dl_prev_q;
        wr_en   = ioctl_wr & ioctl_download & (state_q == SCAN);
        seq     = (cnt_q != 2'd0) && (ioctl_addr == prev_q + 17'd1);
        n0      = w1_q;
        n1      = w2_q;
        n2      = ioctl_dout;
        ncnt    = seq ? ((cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1) : 2'd1;
        abs_hit = (ncnt == 2'd3) && (n0 inside {8'h8D, 8'hAD, 8'h2C}) && (n2[4:0] == 5'h1F);
        match[H_F8] = abs_hit && (n1 inside {[8'hF8:8'hF9]});
        match[H_F6] = abs_hit && (n1 inside {[8'hF6:8'hF9]});
        match[H_F4] = abs_hit && (n1 inside {[8'hF4:8'hFB]});
        match[H_E0] = abs_hit && (n1 inside {[8'hE0:8'hF7]});
        match[H_FA] = abs_hit && (n1 inside {[8'hF8:8'hFA]});
        match[H_3F] = (ncnt >= 2'd2) && (n1 == 8'h85) && (n2 == 8'h3F);
        match[H_FE] = (ncnt == 2'd3) && (n0 == 8'h20) && (n2 inside {8'hD0, 8'hF0});
        a1      = {1'b0, ioctl_addr} + 18'd1;
        bank    = ioctl_addr[16:12];
        off     = ioctl_addr[11:0];
        // Banks never written are ignored; a written bank needs its offset-0 flag intact.
        sc_det  = (size_q >= 18'd8192) && (&(sc_flag_q | ~sc_wr_q));
        bs_8k   = (hit_q[H_3F] >= HIT_W'(2)) ? 4'd5 :
                  (hit_q[H_E0] >= HIT_W'(4)) ? 4'd4 :
                  (hit_q[H_FE] >= HIT_W'(2)) ? 4'd3 : 4'd1;
        bs      = (ext_bs != 4'd0)        ? ext_bs :
                  (size_q <= 18'd4096)    ? 4'd0   :
                  (size_q == 18'd8192)    ? bs_8k  :
                  (size_q == 18'd12288)   ? 4'd8   :
                  (size_q == 18'd16384)   ? 4'd2   :
                  (size_q == 18'd32768)   ? 4'd6   :
                  (hit_q[H_3F] >= HIT_W'(2)) ? 4'd5 : 4'd0;
        state_d    = state_q;
        w0_d       = w0_q;
        w1_d       = w1_q;
        w2_d       = w2_q;
        cnt_d      = cnt_q;
        prev_d     = prev_q;
        size_d     = size_q;
        hit_d      = hit_q;
        sc_flag_d  = sc_flag_q;
        sc_wr_d    = sc_wr_q;
        sc_ref_d   = sc_ref_q;
        force_bs_d = force_bs_q;
        sc_d       = sc_q;
        rom_size_d = rom_size_q;
        valid_d    = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (rise) begin
                    state_d   = SCAN;
                    cnt_d     = 2'd0;
                    size_d    = 18'd0;
                    hit_d     = '{default: '0};
                    sc_flag_d = 32'd0;
                    sc_wr_d   = 32'd0;
                    valid_d   = 1'b0;
                end
            end
            SCAN: begin
                if (fall) state_d = DECIDE;
                if (wr_en) begin
                    w0_d   = n0;
                    w1_d   = n1;
                    w2_d   = n2;
                    cnt_d  = ncnt;
                    prev_d = ioctl_addr;
                    if (a1 > size_q) size_d = a1;
                    for (int i = 0; i < 7; i++)
                        if (match[i] && hit_q[i] != '1) hit_d[i] = hit_q[i] + 1'b1;
                    sc_wr_d[bank] = 1'b1;
                    if (off == 12'd0) begin
                        sc_flag_d[bank] = 1'b1;
                        sc_ref_d[bank]  = ioctl_dout;
                    end else if (32'(off) < SC_LEN && ioctl_dout != sc_ref_q[bank]) begin
                        sc_flag_d[bank] = 1'b0;
                    end
                end
            end
            DECIDE: begin
                state_d    = DONE;
                force_bs_d = bs;
                sc_d       = sc_cfg | sc_det;
                rom_size_d = size_q[16:0];
                valid_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            dl_q       <= 1'b0;
            dl_prev_q  <= 1'b0;
            w0_q       <= 8'd0;
            w1_q       <= 8'd0;
            w2_q       <= 8'd0;
            cnt_q      <= 2'd0;
            prev_q     <= 17'd0;
            size_q     <= 18'd0;
            hit_q      <= '{default: '0};
            sc_flag_q  <= 32'd0;
            sc_wr_q    <= 32'd0;
            sc_ref_q   <= '{default: '0};
            force_bs_q <= 4'd0;
            sc_q       <= 1'b0;
            rom_size_q <= 17'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dl_q       <= ioctl_download;
            dl_prev_q  <= dl_q;
            w0_q       <= w0_d;
            w1_q       <= w1_d;
            w2_q       <= w2_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            size_q     <= size_d;
            hit_q      <= hit_d;
            sc_flag_q  <= sc_flag_d;
            sc_wr_q    <= sc_wr_d;
            sc_ref_q   <= sc_ref_d;
            force_bs_q <= force_bs_d;
            sc_q       <= sc_d;
            rom_size_q <= rom_size_d;
            valid_q    <= valid_d;
        end
    end
endmodule

// File: tb/tb_a2600_bs_detect.sv
// tb_a2600_bs_detect: directed image downloads with hand-computed scheme, SuperChip and size results.
module tb_a2600_bs_detect;
    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [16:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [3:0]  ext_bs = '0;
    logic        sc_cfg = 1'b0;
    logic [3:0]  force_bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        valid;
    int          tests = 0;
    int          fails = 0;

    a2600_bs_detect dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ext_bs(ext_bs), .sc_cfg(sc_cfg),
        .force_bs(force_bs), .sc(sc), .rom_size(rom_size), .valid(valid)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] img(input int t, input int a);
        case (t)
            1: return 8'hEA;
            2: return (a == 'h100) ? 8'h8D : (a == 'h101) ? 8'hF9 : (a == 'h102) ? 8'h1F :
                      (a == 'h1100) ? 8'h2C : (a == 'h1101) ? 8'hF8 : (a == 'h1102) ? 8'hFF :
                      ((a & 'hFFF) < 256) ? 8'h00 : 8'hEA;
            3: return (a == 'h10 || a == 'h200) ? 8'h85 : (a == 'h11 || a == 'h201) ? 8'h3F : 8'hEA;
            4: return (a == 'h10FF) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    task automatic wr1(input int a, input logic [7:0] d);
        @(negedge clk_sys);
        ioctl_wr = 1'b1;
        ioctl_addr = 17'(a);
        ioctl_dout = d;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic load(input int t, input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b1;
            ioctl_addr = 17'(a);
            ioctl_dout = img(t, a);
        end
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
    endtask

    task automatic start_dl();
        @(negedge clk_sys);
        ioctl_download = 1'b1;
        repeat (3) @(negedge clk_sys);
    endtask

    task automatic end_dl(input string tag);
        int k;
        k = 0;
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        while (!valid && k < 10) begin
            @(negedge clk_sys);
            k++;
        end
        chk(tag, 32'(valid), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk_sys);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_bs", 32'(force_bs), 0);
        chk("rst_size", 32'(rom_size), 0);
        reset = 1'b0;
        // 4K all EA, explicit latency check
        start_dl();
        load(1, 0, 4095);
        @(negedge clk_sys);
        ioctl_download = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("t1_valid_early", 32'(valid), 0);
        @(negedge clk_sys);
        chk("t1_valid", 32'(valid), 1);
        chk("t1_bs", 32'(force_bs), 0);
        chk("t1_sc", 32'(sc), 0);
        chk("t1_size", 32'(rom_size), 4096);
        // 8K F8 with uniform bank headers -> SuperChip
        start_dl();
        load(2, 0, 8191);
        end_dl("t2_valid");
        chk("t2_bs", 32'(force_bs), 1);
        chk("t2_sc", 32'(sc), 1);
        chk("t2_size", 32'(rom_size), 8192);
        chk("t2_hit_f8", 32'(dut.hit_q[0]), 2);
        chk("t2_hit_e0", 32'(dut.hit_q[3]), 0);
        // 8K 3F, then the same signature with an extension override
        start_dl();
        load(3, 0, 8191);
        end_dl("t3_valid");
        chk("t3_bs", 32'(force_bs), 5);
        chk("t3_sc", 32'(sc), 0);
        ext_bs = 4'd2;
        start_dl();
        load(3, 0, 'h211);
        wr1('h1FFF, 8'hEA);
        end_dl("t3b_valid");
        chk("t3b_bs", 32'(force_bs), 2);
        chk("t3b_size", 32'(rom_size), 8192);
        ext_bs = 4'd0;
        // 16K with bank 1 header broken
        start_dl();
        load(4, 0, 16383);
        end_dl("t4_valid");
        chk("t4_bs", 32'(force_bs), 2);
        chk("t4_sc", 32'(sc), 0);
        chk("t4_size", 32'(rom_size), 16384);
        // reset mid-download, then full 32K
        start_dl();
        load(5, 0, 2999);
        @(negedge clk_sys);
        reset = 1'b1;
        ioctl_download = 1'b0;
        @(negedge clk_sys);
        chk("t5_rst_valid", 32'(valid), 0);
        chk("t5_rst_bs", 32'(force_bs), 0);
        chk("t5_rst_size", 32'(rom_size), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("t5_idle_valid", 32'(valid), 0);
        start_dl();
        load(5, 0, 32767);
        end_dl("t5_valid");
        chk("t5_bs", 32'(force_bs), 6);
        chk("t5_size", 32'(rom_size), 32768);
        chk("t5_sc", 32'(sc), 1);
        // address jump splits the signature
        start_dl();
        wr1('hFF, 8'h8D);
        wr1('h100, 8'hF9);
        wr1('h200, 8'h1F);
        end_dl("t6_valid");
        chk("t6_hit_f8", 32'(dut.hit_q[0]), 0);
        chk("t6_size", 32'(rom_size), 'h201);
        chk("t6_bs", 32'(force_bs), 0);
        // 20 F8 hits saturate the counter; sc_cfg forces sc
        sc_cfg = 1'b1;
        start_dl();
        for (int r = 0; r < 20; r++) begin
            wr1(3 * r, 8'h8D);
            wr1(3 * r + 1, 8'hF8);
            wr1(3 * r + 2, 8'h1F);
        end
        end_dl("t7_valid");
        chk("t7_hit_sat", 32'(dut.hit_q[0]), 15);
        chk("t7_sc", 32'(sc), 1);
        chk("t7_size", 32'(rom_size), 60);
        sc_cfg = 1'b0;
        // zero-write download with extension code
        ext_bs = 4'd3;
        start_dl();
        end_dl("t8_valid");
        chk("t8_bs", 32'(force_bs), 3);
        chk("t8_size", 32'(rom_size), 0);
        chk("t8_sc", 32'(sc), 0);
        ext_bs = 4'd0;
        // 12K
        start_dl();
        load(6, 0, 255);
        wr1('h2FFF, 8'h00);
        end_dl("t9_valid");
        chk("t9_bs", 32'(force_bs), 8);
        chk("t9_size", 32'(rom_size), 12288);
        chk("t9_sc", 32'(sc), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/a2600_bs_detect.md
Name: a2600_bs_detect

Overview:
- Scans the cartridge image as it streams into the ROM dpram over the ioctl download bus.
- Infers the bank-switch scheme and SuperChip RAM presence, then latches the image size.
- Feeds A2601top's force_bs, sc and rom_size inputs, replacing the extension-only selection in emu.
- A nonzero extension code from emu still overrides the detected scheme.

Parameters:
- HIT_W, 4, width of each saturating signature hit counter.
- SC_LEN, 256, bytes at the start of each 4K bank that must be uniform to flag SuperChip.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ioctl_download  in  1  download in progress.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  17  byte address of ioctl_dout.
- ioctl_dout  in  8  byte being written.
- ext_bs  in  4  scheme code from file extension; 0 means none.
- sc_cfg  in  1  SuperChip OSD option.
- force_bs  out  4  scheme: 0 auto/2K/4K, 1 F8, 2 F6, 3 FE, 4 E0, 5 3F, 6 F4, 7 P2, 8 FA.
- sc  out  1  SuperChip enable.
- rom_size  out  17  byte count of the image (highest written address + 1).
- valid  out  1  outputs are final for the current image.

Behaviour:
- Reset: force_bs=0, sc=0, rom_size=0, valid=0, FSM=IDLE, all counters and flags cleared. Asserting reset mid-download abandons the scan; after reset the block waits for the next rising edge of ioctl_download.
- ioctl_download is registered; edges are detected on the registered copy.
- FSM states: IDLE, SCAN, DECIDE, DONE.
  - IDLE/DONE -> SCAN on a download rising edge. Entry clears hit counters, window, size, SuperChip flags and valid. Outputs hold their old values until DECIDE.
  - SCAN -> DECIDE on a download falling edge.
  - DECIDE -> DONE after exactly one cycle. force_bs, sc and rom_size update on the DECIDE->DONE edge; valid=1 in the same cycle. Latency is 2 clk_sys after the registered download falls.
  - A rising edge seen in DONE restarts SCAN.
- Window, SCAN only:
  - 3-byte shift window w0 (oldest), w1, w2, advanced on each ioctl_wr.
  - If ioctl_addr != previous address + 1, the window restarts with the current byte as its only valid entry.
  - A window is complete when 3 consecutive bytes are valid.
- Signatures: an abs hit needs w0 in {8D, AD, 2C} and w2[4:0]=1F. The lo-byte ranges below are on w1.
  - F8: w1 in F8..F9.
  - F6: w1 in F6..F9.
  - F4: w1 in F4..FB.
  - E0: w1 in E0..F7.
  - FA: w1 in F8..FA.
  - 3F: w1=85 and w2=3F, no abs condition; checked on a 2-byte pair.
  - FE: w0=20, w1 any, w2 in {D0, F0}.
  - Each counter saturates at 2^HIT_W-1; it never wraps.
- size = max(ioctl_addr)+1 over writes. Addresses above 1FFFF are impossible, since ioctl_addr is 17 bits.
- SuperChip:
  - Tracked per 4K bank (addr[16:12]); up to 32 banks, one flag each.
  - A bank's flag is set on its offset-0 byte and cleared on any byte at offset < SC_LEN that differs from that byte.
  - Bytes at offset >= SC_LEN do not affect the flag.
  - A bank never written at offset 0 counts as not flagged.
  - sc_det = (size >= 8192) and all written banks flagged.
- Decision, DECIDE state; first matching rule wins:
  - 1. ext_bs != 0 -> ext_bs.
  - 2. size <= 4096 -> 0.
  - 3. size = 8192: 3F hits >= 2 -> 5; else E0 hits >= 4 -> 4; else FE hits >= 2 -> 3; else 1.
  - 4. size = 12288 -> 8.
  - 5. size = 16384 -> 2.
  - 6. size = 32768 -> 6.
  - 7. Otherwise, 3F hits >= 2 -> 5; else 0.
  - sc = sc_cfg | sc_det. ext_bs never suppresses sc_det.
- ioctl_wr with ioctl_download low is ignored.
- A download with zero writes yields size=0 and force_bs=ext_bs (or 0 if ext_bs=0). valid still asserts.

Test Plan:
- 4096-byte image, all EA, ext_bs=0, sc_cfg=0 -> force_bs=0, sc=0, rom_size=4096, valid high 2 cycles after download falls.
- 8192-byte image, filler EA, containing 8D F9 1F at 0x0100 and 2C F8 FF at 0x1100; bank offsets 0..255 filled with 00 -> force_bs=1, sc=1, rom_size=8192.
- 8192-byte image with 85 3F at 0x0010 and 0x0200 -> force_bs=5; same image with ext_bs=2 -> force_bs=2.
- 16384-byte image, byte 0x10FF=01, rest 00 -> force_bs=2, sc=0 (bank 1 breaks uniformity).
- Assert reset at byte 3000 of a 32K load, release, then perform a full 32K load -> valid=0 during reset, final force_bs=6, rom_size=32768.
- Non-sequential write address (jump 0x0100->0x0200) splitting 8D F9|1F -> F8 counter unchanged; 12288-byte image -> force_bs=8.
